// File: rtl/multicycle_controller.sv
// multicycle_controller
// Main control FSM for the multi-cycle RV32 core. Steps the shared datapath
// through FETCH/DECODE/EXEC/MEM/WB one instruction at a time, decoding from
// the IR opcode/funct3. It waits on the memory ready handshake, traps on bus
// timeouts and illegal opcodes, and counts retired instructions.
//
// state  | meaning
// -------+-------------------------------------------------------------
// FETCH  | imem_re high; on mem_ready latch IR/old_pc and advance PC by 4
// DECODE | one idle cycle while the IR settles; choose EXEC, WB or TRAP
// EXEC   | ALU operand select; branches and jumps finish here
// MEM    | hold dmem_re (load) or dmem_we (store) until mem_ready
// WB     | register file write; instruction retires
// TRAP   | all strobes low, trap high; left only through rst
//
// Every output is forced to 0 while rst_i is high, so a reset in the middle
// of an instruction cannot leave a partial register or memory write behind.

module multicycle_controller #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [6:0]       opcode_i,
  input  logic [2:0]       funct3_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             imem_re_o,
  output logic             ir_we_o,
  output logic             pc_we_o,
  output logic [1:0]       pc_src_o,
  output logic             alu_src_a_o,
  output logic             alu_src_b_o,
  output logic             rf_we_o,
  output logic             dmem_re_o,
  output logic             dmem_we_o,
  output logic [2:0]       state_o,
  output logic             instr_done_o,
  output logic             trap_o,
  output logic [1:0]       trap_cause_o,
  output logic [CNT_W-1:0] instret_o
);

  // State encoding is visible on state_o, so these values are fixed.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_TRAP   = 3'd7;

  // Opcode map shared with the rest of the core.
  localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
  localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
  localparam logic [6:0] OPCODE_S_TYPE = 7'b0100011;
  localparam logic [6:0] OPCODE_B_TYPE = 7'b1100011;
  localparam logic [6:0] OPCODE_J_TYPE = 7'b1101111;
  localparam logic [6:0] OPCODE_U_TYPE = 7'b0110111;
  localparam logic [2:0] FUNCT3_LW     = 3'b010;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

  // The wait counter only has to reach MEM_TIMEOUT-1; the trap fires on the
  // next stalled cycle instead of counting further.
  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  logic [2:0]       state_q,      state_d;
  logic [WAIT_W-1:0] wait_cnt_q,  wait_cnt_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [CNT_W-1:0] instret_q,    instret_d;

  logic       is_r, is_i, is_s, is_b, is_j, is_u;
  logic       is_load;
  logic       wait_expired;
  logic [1:0] cause_new;

  logic       imem_re, ir_we, pc_we, alu_src_a, alu_src_b;
  logic       rf_we, dmem_re, dmem_we, instr_done;
  logic [1:0] pc_src;

  assign is_r    = (opcode_i == OPCODE_R_TYPE);
  assign is_i    = (opcode_i == OPCODE_I_TYPE);
  assign is_s    = (opcode_i == OPCODE_S_TYPE);
  assign is_b    = (opcode_i == OPCODE_B_TYPE);
  assign is_j    = (opcode_i == OPCODE_J_TYPE);
  assign is_u    = (opcode_i == OPCODE_U_TYPE);
  assign is_load = is_i && (funct3_i == FUNCT3_LW);

  // A ready in the last allowed cycle still wins over the timeout.
  assign wait_expired = !mem_ready_i && (wait_cnt_q == WAIT_LAST);

  // Next-state selection and the trap cause that accompanies a trap entry.
  always_comb begin
    state_d   = state_q;
    cause_new = CAUSE_NONE;
    case (state_q)
      S_FETCH: begin
        if (mem_ready_i) begin
          state_d = S_DECODE;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          cause_new = CAUSE_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (is_r || is_i || is_s || is_b || is_j) begin
          state_d = S_EXEC;
        end else if (is_u) begin
          state_d = S_WB;
        end else begin
          state_d   = S_TRAP;
          cause_new = CAUSE_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (is_r) begin
          state_d = S_WB;
        end else if (is_i) begin
          state_d = is_load ? S_MEM : S_WB;
        end else if (is_s) begin
          state_d = S_MEM;
        end else if (is_b || is_j) begin
          state_d = S_FETCH;
        end else begin
          // IR changed under us after DECODE; treat it as an illegal opcode.
          state_d   = S_TRAP;
          cause_new = CAUSE_ILLEGAL;
        end
      end
      S_MEM: begin
        if (mem_ready_i) begin
          state_d = is_s ? S_FETCH : S_WB;
        end else if (wait_expired) begin
          state_d   = S_TRAP;
          cause_new = CAUSE_TIMEOUT;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Datapath strobes decoded from the current state and live handshakes.
  always_comb begin
    imem_re    = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_src_a  = 1'b0;
    alu_src_b  = 1'b0;
    rf_we      = 1'b0;
    dmem_re    = 1'b0;
    dmem_we    = 1'b0;
    instr_done = 1'b0;
    case (state_q)
      S_FETCH: begin
        imem_re = 1'b1;
        if (mem_ready_i) begin
          ir_we  = 1'b1;
          pc_we  = 1'b1;
          pc_src = PC_SRC_SEQ;
        end
      end
      S_EXEC: begin
        if (is_i || is_s) begin
          alu_src_b = 1'b1;
        end else if (is_b) begin
          pc_we      = branch_taken_i;
          pc_src     = PC_SRC_BRANCH;
          instr_done = 1'b1;
        end else if (is_j) begin
          pc_we      = 1'b1;
          pc_src     = PC_SRC_JUMP;
          instr_done = 1'b1;
        end
      end
      S_MEM: begin
        dmem_we = is_s;
        dmem_re = !is_s;
        if (mem_ready_i && is_s) begin
          instr_done = 1'b1;
        end
      end
      S_WB: begin
        rf_we      = 1'b1;
        instr_done = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Sticky trap cause: the first trap reason is kept until reset.
  always_comb begin
    trap_cause_d = trap_cause_q;
    if (trap_cause_q == CAUSE_NONE) begin
      trap_cause_d = cause_new;
    end
  end

  // Stall counter restarts whenever FETCH or MEM is (re)entered.
  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (state_d != state_q) begin
      wait_cnt_d = '0;
    end else if (((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready_i) begin
      wait_cnt_d = wait_cnt_q + WAIT_W'(1);
    end
  end

  // Retired count advances on each completing instruction and wraps.
  always_comb begin
    instret_d = instret_q;
    if (instr_done) begin
      instret_d = instret_q + CNT_W'(1);
    end
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory wait counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Trap cause register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trap_cause_q <= CAUSE_NONE;
    end else begin
      trap_cause_q <= trap_cause_d;
    end
  end

  // Retired-instruction counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  // Outputs are held at zero for the whole reset cycle.
  always_comb begin
    imem_re_o    = imem_re;
    ir_we_o      = ir_we;
    pc_we_o      = pc_we;
    pc_src_o     = pc_src;
    alu_src_a_o  = alu_src_a;
    alu_src_b_o  = alu_src_b;
    rf_we_o      = rf_we;
    dmem_re_o    = dmem_re;
    dmem_we_o    = dmem_we;
    instr_done_o = instr_done;
    state_o      = state_q;
    trap_o       = (state_q == S_TRAP);
    trap_cause_o = trap_cause_q;
    instret_o    = instret_q;
    if (rst_i) begin
      imem_re_o    = 1'b0;
      ir_we_o      = 1'b0;
      pc_we_o      = 1'b0;
      pc_src_o     = 2'b00;
      alu_src_a_o  = 1'b0;
      alu_src_b_o  = 1'b0;
      rf_we_o      = 1'b0;
      dmem_re_o    = 1'b0;
      dmem_we_o    = 1'b0;
      instr_done_o = 1'b0;
      state_o      = 3'd0;
      trap_o       = 1'b0;
      trap_cause_o = 2'b00;
      instret_o    = '0;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed scenarios plus a randomized
// instruction stream checked against per-instruction latency and strobe totals.
module tb_multicycle_controller;

  localparam int TO = 16;
  localparam int CW = 4;

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] OP_I = 7'b0010011;
  localparam logic [6:0] OP_S = 7'b0100011;
  localparam logic [6:0] OP_B = 7'b1100011;
  localparam logic [6:0] OP_J = 7'b1101111;
  localparam logic [6:0] OP_U = 7'b0110111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [6:0]    opcode = OP_R;
  logic [2:0]    funct3 = 3'b000;
  logic          branch_taken = 1'b0;
  logic          mem_ready = 1'b0;
  logic          imem_re, ir_we, pc_we, alu_src_a, alu_src_b;
  logic          rf_we, dmem_re, dmem_we, instr_done, trap;
  logic [1:0]    pc_src, trap_cause;
  logic [2:0]    state;
  logic [CW-1:0] instret;

  int errors = 0;
  int checks = 0;

  logic [10:0]   s_strobes;
  logic [2:0]    s_state;
  logic          s_trap;
  logic [1:0]    s_cause;
  logic [CW-1:0] s_instret;

  multicycle_controller #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct3_i(funct3),
    .branch_taken_i(branch_taken), .mem_ready_i(mem_ready),
    .imem_re_o(imem_re), .ir_we_o(ir_we), .pc_we_o(pc_we), .pc_src_o(pc_src),
    .alu_src_a_o(alu_src_a), .alu_src_b_o(alu_src_b), .rf_we_o(rf_we),
    .dmem_re_o(dmem_re), .dmem_we_o(dmem_we), .state_o(state),
    .instr_done_o(instr_done), .trap_o(trap), .trap_cause_o(trap_cause),
    .instret_o(instret)
  );

  always #5 clk = ~clk;

  // strobe vector bit order: imem_re ir_we pc_we pc_src[1:0] a b rf_we dre dwe done
  task automatic step(input logic r, input logic rdy, input logic bt);
    rst = r; mem_ready = rdy; branch_taken = bt;
    #1;
    s_strobes = {imem_re, ir_we, pc_we, pc_src, alu_src_a, alu_src_b,
                 rf_we, dmem_re, dmem_we, instr_done};
    s_state = state; s_trap = trap; s_cause = trap_cause; s_instret = instret;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_reset();
    opcode = OP_S;
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b1);
      checks++;
      if ({s_strobes, s_state, s_trap, s_cause, s_instret} !== '0) begin
        errors++;
        $display("FAIL reset_outputs_zero got strobes=%b state=%0d trap=%b cause=%0d instret=%0d want all 0",
                 s_strobes, s_state, s_trap, s_cause, s_instret);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (s_state !== 3'd0 || s_strobes !== 11'b100_0000_0000 || s_instret !== '0 || s_cause !== 2'd0) begin
      errors++;
      $display("FAIL reset_release got state=%0d strobes=%b instret=%0d cause=%0d want state=0 imem_re only",
               s_state, s_strobes, s_instret, s_cause);
    end
  endtask

  task automatic test_r_add();
    logic [2:0] exp_st [4] = '{3'd0, 3'd1, 3'd2, 3'd4};
    do_reset();
    opcode = OP_R; funct3 = 3'b000;
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (s_state !== exp_st[k] || s_strobes[3] !== (k == 3) || s_strobes[0] !== (k == 3)) begin
        errors++;
        $display("FAIL r_add_cycle%0d got state=%0d rf_we=%b done=%b want state=%0d rf_we=done=%b",
                 k, s_state, s_strobes[3], s_strobes[0], exp_st[k], (k == 3));
      end
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd0 || s_instret !== 4'd1) begin
      errors++;
      $display("FAIL r_add_retire got state=%0d instret=%0d want 0 and 1", s_state, s_instret);
    end
  endtask

  task automatic test_lw_wait();
    logic [2:0] exp_st [8] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3, 3'd3, 3'd3, 3'd4};
    logic       rdy    [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    int dre = 0;
    do_reset();
    opcode = OP_I; funct3 = 3'b010;
    for (int k = 0; k < 8; k++) begin
      step(1'b0, rdy[k], 1'b0);
      dre += int'(s_strobes[2]);
      checks++;
      if (s_state !== exp_st[k] || s_strobes[3] !== (k == 7) || s_strobes[0] !== (k == 7)) begin
        errors++;
        $display("FAIL lw_cycle%0d got state=%0d rf_we=%b done=%b want state=%0d rf_we=done=%b",
                 k, s_state, s_strobes[3], s_strobes[0], exp_st[k], (k == 7));
      end
    end
    checks++;
    if (dre != 4) begin
      errors++;
      $display("FAIL lw_dmem_re_cycles got %0d want 4", dre);
    end
  endtask

  task automatic test_branch();
    for (int t = 0; t < 2; t++) begin
      do_reset();
      opcode = OP_B; funct3 = 3'b000;
      step(1'b0, 1'b1, t[0]);
      step(1'b0, 1'b1, t[0]);
      step(1'b0, 1'b1, t[0]);
      checks++;
      if (s_state !== 3'd2 || s_strobes[8] !== t[0] || s_strobes[7:6] !== 2'b01 || s_strobes[0] !== 1'b1) begin
        errors++;
        $display("FAIL branch_exec_taken%0d got state=%0d pc_we=%b pc_src=%b done=%b want 2 %b 01 1",
                 t, s_state, s_strobes[8], s_strobes[7:6], s_strobes[0], t[0]);
      end
      step(1'b0, 1'b1, 1'b0);
      checks++;
      if (s_state !== 3'd0 || s_instret !== 4'd1) begin
        errors++;
        $display("FAIL branch_len_taken%0d got state=%0d instret=%0d want 0 and 1", t, s_state, s_instret);
      end
    end
  endtask

  task automatic test_illegal();
    do_reset();
    opcode = OP_U;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    opcode = 7'b1111111;
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd1) begin
      errors++;
      $display("FAIL illegal_decode got state=%0d want 1", s_state);
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 1'b1);
      checks++;
      if (s_state !== 3'd7 || s_trap !== 1'b1 || s_cause !== 2'b01 || s_strobes !== '0 || s_instret !== 4'd1) begin
        errors++;
        $display("FAIL illegal_trap%0d got state=%0d trap=%b cause=%0d strobes=%b instret=%0d want 7 1 1 0 1",
                 k, s_state, s_trap, s_cause, s_strobes, s_instret);
      end
    end
  endtask

  task automatic test_timeout();
    do_reset();
    opcode = OP_R;
    for (int k = 0; k < TO; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (s_state !== 3'd0 || s_trap !== 1'b0) begin
      errors++;
      $display("FAIL fetch_wait_last got state=%0d trap=%b want 0 0", s_state, s_trap);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd7 || s_cause !== 2'b10 || s_strobes !== '0) begin
      errors++;
      $display("FAIL fetch_timeout got state=%0d cause=%0d strobes=%b want 7 2 0", s_state, s_cause, s_strobes);
    end
    do_reset();
    for (int k = 0; k < TO - 1; k++) step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd0 || s_strobes[9] !== 1'b1) begin
      errors++;
      $display("FAIL fetch_late_ready got state=%0d ir_we=%b want 0 1", s_state, s_strobes[9]);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd1 || s_trap !== 1'b0 || s_cause !== 2'b00) begin
      errors++;
      $display("FAIL fetch_no_trap got state=%0d trap=%b cause=%0d want 1 0 0", s_state, s_trap, s_cause);
    end
    do_reset();
    opcode = OP_S;
    for (int k = 0; k < 3; k++) step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < TO; k++) step(1'b0, 1'b0, 1'b0);
    checks++;
    if (s_state !== 3'd3 || s_strobes[1] !== 1'b1) begin
      errors++;
      $display("FAIL mem_wait_last got state=%0d dmem_we=%b want 3 1", s_state, s_strobes[1]);
    end
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_state !== 3'd7 || s_cause !== 2'b10 || s_instret !== 4'd0) begin
      errors++;
      $display("FAIL mem_timeout got state=%0d cause=%0d instret=%0d want 7 2 0", s_state, s_cause, s_instret);
    end
  endtask

  task automatic test_wrap_and_abort();
    do_reset();
    opcode = OP_U;
    for (int i = 0; i < 17; i++) begin
      for (int k = 0; k < 3; k++) begin
        step(1'b0, 1'b1, 1'b0);
        if (k == 0 && (i == 15 || i == 16)) begin
          checks++;
          if (s_instret !== CW'(i)) begin
            errors++;
            $display("FAIL instret_wrap_at%0d got %0d want %0d", i, s_instret, i % 16);
          end
        end
      end
    end
    opcode = OP_S;
    step(1'b0, 1'b1, 1'b0);
    checks++;
    if (s_instret !== 4'd1) begin
      errors++;
      $display("FAIL instret_after_wrap got %0d want 1", s_instret);
    end
    step(1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    checks++;
    if (s_strobes !== '0) begin
      errors++;
      $display("FAIL abort_store_strobes got %b want 0", s_strobes);
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (s_state !== 3'd0 || s_instret !== 4'd0 || s_strobes[10] !== 1'b1) begin
      errors++;
      $display("FAIL abort_restart got state=%0d instret=%0d imem_re=%b want 0 0 1",
               s_state, s_instret, s_strobes[10]);
    end
  endtask

  // Reference: each instruction class has a fixed phase list; waits stretch
  // the fetch and the memory phase. Totals of each strobe follow directly.
  task automatic test_random();
    logic [6:0] ops [7] = '{OP_R, OP_I, OP_I, OP_S, OP_B, OP_J, OP_U};
    int m_instret = 0;
    do_reset();
    for (int n = 0; n < 40; n++) begin
      int cls = $urandom_range(0, 6);
      int fw  = $urandom_range(0, 3);
      int mw  = $urandom_range(0, 3);
      logic bt = 1'($urandom_range(0, 1));
      int len, e_rf, e_dre, e_dwe, e_pcwe, e_imem;
      int c_rf = 0, c_dre = 0, c_dwe = 0, c_pcwe = 0, c_imem = 0, c_ir = 0;
      bit has_mem, done_bad = 0, start_bad = 0;
      opcode = ops[cls];
      funct3 = 3'($urandom_range(0, 7));
      if (cls == 2) funct3 = 3'b010;
      else if (cls == 1 && funct3 == 3'b010) funct3 = 3'b000;
      has_mem = (cls == 2 || cls == 3);
      case (cls)
        0, 1: len = fw + 4;
        2:    len = fw + 5 + mw;
        3:    len = fw + 4 + mw;
        default: len = fw + 3;
      endcase
      e_rf   = (cls <= 2 || cls == 6) ? 1 : 0;
      e_dre  = (cls == 2) ? mw + 1 : 0;
      e_dwe  = (cls == 3) ? mw + 1 : 0;
      e_pcwe = 1 + ((cls == 4) ? int'(bt) : 0) + ((cls == 5) ? 1 : 0);
      e_imem = fw + 1;
      for (int k = 0; k < len; k++) begin
        logic rdy = 1'b1;
        if (k < fw) rdy = 1'b0;
        if (has_mem && k >= fw + 3 && k < fw + 3 + mw) rdy = 1'b0;
        step(1'b0, rdy, bt);
        if (k == 0 && (s_state !== 3'd0 || s_instret !== CW'(m_instret))) start_bad = 1;
        if (s_strobes[0] !== (k == len - 1)) done_bad = 1;
        c_imem += int'(s_strobes[10]);
        c_ir   += int'(s_strobes[9]);
        c_pcwe += int'(s_strobes[8]);
        c_rf   += int'(s_strobes[3]);
        c_dre  += int'(s_strobes[2]);
        c_dwe  += int'(s_strobes[1]);
      end
      m_instret = (m_instret + 1) % (1 << CW);
      checks++;
      if (start_bad) begin
        errors++;
        $display("FAIL rnd%0d_start got state=%0d instret=%0d want 0 and %0d",
                 n, s_state, s_instret, (m_instret + 15) % 16);
      end
      checks++;
      if (done_bad) begin
        errors++;
        $display("FAIL rnd%0d_done_timing cls=%0d got done pattern off want done only at cycle %0d", n, cls, len - 1);
      end
      checks++;
      if (c_rf != e_rf || c_dre != e_dre || c_dwe != e_dwe) begin
        errors++;
        $display("FAIL rnd%0d_data_strobes cls=%0d got rf=%0d dre=%0d dwe=%0d want %0d %0d %0d",
                 n, cls, c_rf, c_dre, c_dwe, e_rf, e_dre, e_dwe);
      end
      checks++;
      if (c_pcwe != e_pcwe || c_imem != e_imem || c_ir != 1) begin
        errors++;
        $display("FAIL rnd%0d_fetch_strobes cls=%0d got pc_we=%0d imem_re=%0d ir_we=%0d want %0d %0d 1",
                 n, cls, c_pcwe, c_imem, c_ir, e_pcwe, e_imem);
      end
    end
    step(1'b0, 1'b0, 1'b0);
    checks++;
    if (s_instret !== CW'(m_instret) || s_state !== 3'd0) begin
      errors++;
      $display("FAIL rnd_final got instret=%0d state=%0d want %0d 0", s_instret, s_state, m_instret);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_r_add();
    test_lw_wait();
    test_branch();
    test_illegal();
    test_timeout();
    test_wrap_and_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
